// File: rtl/tt_um_emern_update_sched.sv
// rtl/tt_um_emern_update_sched.sv - vblank-gated command FIFO that commits polygon/bg updates in bursts
module tt_um_emern_update_sched #(
  parameter int DEPTH         = 4,
  parameter int MAX_PER_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [44:0] cmd_payload,
  input  logic        vblank,
  output logic        wr_en,
  output logic [1:0]  wr_sel,
  output logic        wr_clear,
  output logic [44:0] wr_data,
  output logic        burst_done,
  output logic        err_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [3:0]    MAX_C   = 4'(MAX_PER_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BURST} state_t;

  // Entries are stored already decoded: {sel[1:0], clear, data[44:0]}
  logic [47:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_budget;
  logic          r_vb_q;
  logic          r_err;
  state_t        r_state;
  logic          r_wr_en;
  logic [1:0]    r_wr_sel;
  logic          r_wr_clear;
  logic [44:0]   r_wr_data;
  logic          r_burst_done;

  state_t        w_state_next;
  logic          w_op_valid;
  logic [47:0]   w_dec;
  logic [47:0]   w_head;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_exit;
  logic          w_rise;
  logic [CW-1:0] w_count_next;

  // Ready depends only on occupancy so upstream never sees a pop-dependent path
  assign cmd_ready = (r_count < DEPTH_C);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_push    = w_accept & w_op_valid;
  assign w_rise    = vblank & ~r_vb_q;
  assign w_head    = r_mem[r_rd_ptr];

  assign wr_en      = r_wr_en;
  assign wr_sel     = r_wr_sel;
  assign wr_clear   = r_wr_clear;
  assign wr_data    = r_wr_data;
  assign burst_done = r_burst_done;
  assign err_drop   = r_err;

  // Opcode decode into the register-bank write that the command will become
  always_comb begin
    w_op_valid = 1'b0;
    w_dec      = '0;
    case (cmd_op)
      8'h80:   begin w_op_valid = 1'b1; w_dec = {2'd0, 1'b0, cmd_payload}; end
      8'h81:   begin w_op_valid = 1'b1; w_dec = {2'd1, 1'b0, cmd_payload}; end
      8'h82:   begin w_op_valid = 1'b1; w_dec = {2'd2, 1'b0, cmd_payload}; end
      8'h40:   begin w_op_valid = 1'b1; w_dec = {2'd0, 1'b1, 45'd0}; end
      8'h41:   begin w_op_valid = 1'b1; w_dec = {2'd1, 1'b1, 45'd0}; end
      8'h42:   begin w_op_valid = 1'b1; w_dec = {2'd2, 1'b1, 45'd0}; end
      8'h01:   begin w_op_valid = 1'b1; w_dec = {2'd3, 1'b0, 39'd0, cmd_payload[5:0]}; end
      default: begin w_op_valid = 1'b0; w_dec = '0; end
    endcase
  end

  // FSM outputs: pop while the burst may continue, otherwise leave the burst
  always_comb begin
    w_pop  = 1'b0;
    w_exit = 1'b0;
    if (r_state == S_BURST) begin
      if (vblank && (r_count != '0) && (r_budget < MAX_C)) w_pop = 1'b1;
      else                                                 w_exit = 1'b1;
    end
  end

  // Occupancy after this edge; push and pop together leave it unchanged
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Next-state: a rise only starts a burst if there is something to commit
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_rise && ((r_count != '0) || w_push)) w_state_next = S_BURST;
        else if (w_count_next != '0)               w_state_next = S_ARMED;
      end
      S_ARMED: begin
        if (w_rise) w_state_next = S_BURST;
      end
      S_BURST: begin
        if (w_exit) w_state_next = (w_count_next != '0) ? S_ARMED : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_next;
    end
  end

  // FIFO storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  // Burst budget, vblank edge history and the sticky drop flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_budget <= '0;
      r_vb_q   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_vb_q <= vblank;
      if (w_accept && !w_op_valid) r_err <= 1'b1;
      if (w_exit)     r_budget <= '0;
      else if (w_pop) r_budget <= r_budget + 4'd1;
    end
  end

  // Registered write strobe; fields are zero whenever nothing commits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en      <= 1'b0;
      r_wr_sel     <= '0;
      r_wr_clear   <= 1'b0;
      r_wr_data    <= '0;
      r_burst_done <= 1'b0;
    end else begin
      r_wr_en      <= w_pop;
      r_burst_done <= w_exit;
      if (w_pop) begin
        r_wr_sel   <= w_head[47:46];
        r_wr_clear <= w_head[45];
        r_wr_data  <= w_head[44:0];
      end else begin
        r_wr_sel   <= '0;
        r_wr_clear <= 1'b0;
        r_wr_data  <= '0;
      end
    end
  end

endmodule

// File: doc/tt_um_emern_update_sched.md
TT_UM_EMERN_UPDATE_SCHED -- requirements
Module: tt_um_emern_update_sched

Interface
REQ-001 SHALL have parameters: DEPTH, default 4, command FIFO entries (power of 2, >=2); MAX_PER_BURST, default 4, commits allowed per vblank burst (1..15).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  upstream command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at clk edge.
REQ-006 SHALL have port cmd_op  input  8  opcode: 8'h80/81/82 write poly A/B/C, 8'h40/41/42 clear poly A/B/C, 8'h01 set bg color.
REQ-007 SHALL have port cmd_payload  input  45  packed {v2_y[6],v1_y[6],v0_y[6],v2_x[7],v1_x[7],v0_x[7],color[6]}, color at LSBs.
REQ-008 SHALL have port vblank  input  1  level, high during vertical blanking, synchronous to clk.
REQ-009 SHALL have port wr_en  output  1  one-cycle register-bank write strobe.
REQ-010 SHALL have port wr_sel  output  2  target: 0/1/2 = poly A/B/C, 3 = bg color.
REQ-011 SHALL have port wr_clear  output  1  write is a clear (poly disable).
REQ-012 SHALL have port wr_data  output  45  payload for the write, same packing as cmd_payload.
REQ-013 SHALL have port burst_done  output  1  one-cycle pulse when a commit burst ends.
REQ-014 SHALL have port err_drop  output  1  sticky: an unrecognized opcode was accepted and discarded.

Function
REQ-015 SHALL hold accepted commands in a DEPTH-entry FIFO; cmd_ready = (count < DEPTH), independent of same-cycle pop.
REQ-016 SHALL accept and discard any opcode outside REQ-006 (not enqueued), setting err_drop on the accepting edge.
REQ-017 SHALL register vblank once (vb_q) and detect vblank rise as vblank & ~vb_q.
REQ-018 SHALL implement FSM states IDLE (FIFO empty), ARMED (FIFO non-empty, awaiting vblank rise), BURST (committing).
REQ-019 SHALL transition IDLE->ARMED when count becomes non-zero; ARMED->IDLE never (only via BURST).
REQ-020 SHALL enter BURST from IDLE or ARMED on a vblank rise edge when count>0 or a push occurs that edge; a rise with empty FIFO and no push SHALL NOT start a burst.
REQ-021 SHALL, in each BURST cycle with vblank high, count>0 and budget<MAX_PER_BURST, pop the FIFO head and drive wr_en=1 with its fields registered (1-cycle latency from pop to strobe); budget increments per pop.
REQ-022 SHALL end BURST when vblank low, FIFO empty, or budget==MAX_PER_BURST; next state ARMED if count>0 else IDLE; burst_done pulses 1 cycle on the exit edge; budget clears.
REQ-023 SHALL commit commands pushed during BURST in the same burst if budget and vblank allow; simultaneous push and pop SHALL keep count unchanged.
REQ-024 SHALL map opcodes: write -> wr_sel=index, wr_clear=0, wr_data=payload; clear -> wr_sel=index, wr_clear=1, wr_data=0; bg -> wr_sel=3, wr_clear=0, wr_data={39'b0,payload[5:0]}.
REQ-025 SHALL drive wr_en=0 and hold wr_sel/wr_clear/wr_data at 0 in every cycle with no commit.
REQ-026 SHALL commit in strict FIFO order; pointers wrap modulo DEPTH.

Reset
REQ-027 SHALL on rst high immediately clear FIFO pointers/count, budget, vb_q, err_drop, state=IDLE, all outputs 0 except cmd_ready.
REQ-028 SHALL drive cmd_ready=1 while rst is high and after release; in-flight burst is abandoned with no burst_done.

Verification
REQ-029 Push 80/payload 0x1 with vblank low, raise vblank 3 cycles later -> wr_en once, one cycle after rise edge +1, wr_sel=0, wr_data=0x1; burst_done next cycle.
REQ-030 Push 5 commands with DEPTH=4 -> 5th stalls (cmd_ready=0) until first pop; all 5 commit in order across two vblank bursts (4 then 1).
REQ-031 Push 41 then 01/payload 0x3F -> writes wr_sel=1 wr_clear=1 wr_data=0, then wr_sel=3 wr_data=0x3F.
REQ-032 Push opcode 8'hFF -> accepted, err_drop=1, no wr_en, FIFO count 0; remains 1 until rst.
REQ-033 Drop vblank after 2 of 4 commits -> burst_done, state ARMED, remaining 2 commit at next vblank rise.
REQ-034 Assert rst mid-burst -> wr_en=0 same cycle, FIFO empty, no burst_done; fresh command after release behaves as REQ-029.
